// File: rtl/mdu_unit_if.sv
// Request/result bundle between an issuing core and the multiply/divide unit.
// The requester drives start/mdu_op/a/b; the unit returns busy and the HI/LO registers.
interface mdu_unit_if;
  logic        start;
  logic [3:0]  mdu_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  modport master (output start, mdu_op, a, b, input busy, hi_out, lo_out);
  modport slave  (input start, mdu_op, a, b, output busy, hi_out, lo_out);
endinterface

// File: rtl/mdu_unit.sv
// Iterative-latency HI/LO multiply/divide unit: MULT_CYCLES/DIV_CYCLES busy, start ignored while busy.
// Optional madd/msub accumulate ops are built only when MDU_MADD_EN is defined.
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic       clk,
  input logic       reset,
  mdu_unit_if.slave bus
);
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [3:0]    op_q;
  logic [31:0]   a_q, b_q, hi_q, lo_q;
  logic          accept, done, move_hi, move_lo, is_mult, is_div;

  logic [63:0]   prod_s, prod_u, hilo_res;
  logic [31:0]   a_mag, b_mag, q_mag, r_mag, q_res, r_res;
  logic          signed_div, neg_a, neg_b;

  always_comb begin
    is_mult = 1'b0;
    is_div  = 1'b0;
    case (bus.mdu_op)
      4'd1, 4'd2: is_mult = 1'b1;
      4'd3, 4'd4: is_div  = 1'b1;
`ifdef MDU_MADD_EN
      4'd7, 4'd8: is_mult = 1'b1;
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    done      = 1'b0;
    move_hi   = 1'b0;
    move_lo   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (is_mult || is_div) begin
            accept    = 1'b1;
            state_nxt = BUSY;
            cnt_nxt   = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
          end
          move_hi = (bus.mdu_op == 4'd5);
          move_lo = (bus.mdu_op == 4'd6);
        end
      end
      BUSY: begin
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Division works on magnitudes; signs are restored so the quotient truncates toward
  // zero and the remainder follows the dividend. 0x80000000 / -1 falls out as 0x80000000.
  always_comb begin
    prod_u     = {32'b0, a_q} * {32'b0, b_q};
    prod_s     = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    signed_div = (op_q == 4'd3);
    neg_a      = signed_div & a_q[31];
    neg_b      = signed_div & b_q[31];
    a_mag      = neg_a ? -a_q : a_q;
    b_mag      = neg_b ? -b_q : b_q;
    q_mag      = (b_mag == 32'd0) ? 32'd0 : a_mag / b_mag;
    r_mag      = (b_mag == 32'd0) ? 32'd0 : a_mag % b_mag;
    q_res      = (neg_a ^ neg_b) ? -q_mag : q_mag;
    r_res      = neg_a ? -r_mag : r_mag;

    hilo_res = {hi_q, lo_q};
    case (op_q)
      4'd1:       hilo_res = prod_s;
      4'd2:       hilo_res = prod_u;
      4'd3, 4'd4: if (b_q != 32'd0) hilo_res = {r_res, q_res};
`ifdef MDU_MADD_EN
      // HI/LO cannot change while busy, so the live value equals the one seen at acceptance.
      4'd7:       hilo_res = {hi_q, lo_q} + prod_s;
      4'd8:       hilo_res = {hi_q, lo_q} - prod_s;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (accept) begin
        op_q <= bus.mdu_op;
        a_q  <= bus.a;
        b_q  <= bus.b;
      end
      if (move_hi) hi_q <= bus.a;
      if (move_lo) lo_q <= bus.a;
      if (done) {hi_q, lo_q} <= hilo_res;
    end
  end

  assign bus.busy   = (state == BUSY);
  assign bus.hi_out = hi_q;
  assign bus.lo_out = lo_q;
endmodule

// File: doc/mdu_unit.md
MDU_UNIT -- requirements
Module: mdu_unit

Interface
REQ-001 MULT_CYCLES, 5, busy cycles for mult/multu/madd/msub (integer >= 1).
REQ-002 DIV_CYCLES, 10, busy cycles for div/divu (integer >= 1).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-low reset: state clears on a clk rising edge while reset=0.
REQ-005 start  input  1  request strobe, sampled each rising edge.
REQ-006 mdu_op  input  4  operation code:
- 0 none
- 1 mult
- 2 multu
- 3 div
- 4 divu
- 5 mthi
- 6 mtlo
- 7 madd
- 8 msub
- others reserved.
REQ-007 a  input  32  operand A (dividend / multiplicand / mthi-mtlo source).
REQ-008 b  input  32  operand B (divisor / multiplier).
REQ-009 busy  output  1  high while an arithmetic operation is in flight.
REQ-010 hi_out  output  32  current HI register, driven directly from the register.
REQ-011 lo_out  output  32  current LO register, driven directly from the register.

Function
REQ-012 The unit SHALL implement a two-state FSM:
- IDLE to BUSY on an accepted arithmetic op.
- BUSY to IDLE when the counter expires.
REQ-013 Acceptance: start=1, busy=0, mdu_op in {1,2,3,4,7,8} at edge k SHALL latch a, b and mdu_op, load the counter with MULT_CYCLES or DIV_CYCLES, and set busy=1 after edge k.
REQ-014 busy SHALL stay high for exactly N cycles. At edge k+N, HI/LO SHALL update and busy SHALL fall on that same edge.
REQ-015 start with busy=1 SHALL be ignored (no latch, no HI/LO change). Inputs changing during BUSY SHALL NOT affect the result.
REQ-016 mthi/mtlo with start=1, busy=0 SHALL write a to HI/LO on that edge, with no busy cycle. With busy=1 they SHALL be ignored.
REQ-017 Op 0 or reserved codes with start=1 SHALL produce no state change.
REQ-018 mult/multu SHALL compute the full 64-bit signed/unsigned product: {HI,LO} = product.
REQ-019 div/divu:
- LO = quotient truncated toward zero.
- HI = remainder, taking the sign of the dividend (signed case).
REQ-020 Signed overflow 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-021 Divide by zero SHALL still hold busy for DIV_CYCLES and SHALL leave HI/LO unchanged at completion.
REQ-022 hi_out/lo_out SHALL keep their previous values throughout BUSY. A read in the completion cycle SHALL see the old values; the new values appear the following cycle.

Reset
REQ-023 Reset SHALL set HI=0, LO=0, busy=0, counter=0, FSM=IDLE, and SHALL override start in the same edge.
REQ-024 Reset asserted mid-operation SHALL abort the operation with no HI/LO write of the pending result.

Configuration
REQ-025 Macro MDU_MADD_EN defined:
- madd (7): {HI,LO} += signed a*b, modulo 2^64.
- msub (8): {HI,LO} -= signed a*b, modulo 2^64.
- Both take MULT_CYCLES, using the {HI,LO} value captured at acceptance.
REQ-026 MDU_MADD_EN undefined: codes 7 and 8 SHALL be treated as reserved (REQ-017) and no accumulate hardware SHALL be present.

Verification
REQ-027 mult, a=0xFFFFFFFF, b=2 -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; multu with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-028 div, a=0xFFFFFFF9 (-7), b=2 -> busy high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu a=7, b=2 -> LO=3, HI=1.
REQ-029 mthi a=0x12345678, then div a=5, b=0 -> HI=0x12345678, LO unchanged after 10 busy cycles; a second start on cycle 3 of busy is ignored.
REQ-030 mult 3*4 started, reset=0 on busy cycle 2 -> next cycle busy=0, HI=LO=0, and the result 12 never appears.
REQ-031 With MDU_MADD_EN: mtlo 10, then madd a=3, b=4 -> LO=22, HI=0; msub a=5, b=5 -> {HI,LO} = 0xFFFFFFFF_FFFFFFFD. Without the macro, op 7 with start leaves HI/LO unchanged and busy=0.
REQ-032 Signed div a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0 with no hang; back-to-back mult issued on the cycle busy falls is accepted.
